msi_directory_responder: RTL and testbench
==========================================

Name: msi_directory_responder

Overview:
- Responder end of the MSI directory test request stream: accepts processor requests (address, read/write, processor id, data) and executes them against a 2-processor MSI directory plus backing memory.
- Produces one response per request, plus invalidation and writeback side-channel pulses.
- Sits between the request stimulus generator and the bench scoreboard.

Parameters:
- ADDR_W, 4, address width; directory/memory depth = 2**ADDR_W
- DATA_W, 4, data word width
- MEM_INIT, 0, value loaded into every memory and dirty word at reset

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  responder can accept; high only in IDLE
- AddressTest  in  ADDR_W  request address
- WriteOrRead  in  2  00 read, 01 write, 1x invalid
- Processor  in  2  00 P0,0, 01 P0,1, 1x invalid
- DataTest  in  DATA_W  write data; ignored on read
- RespValid  out  1  one-cycle response strobe
- RespProcessor  out  2  echo of requester id
- RespData  out  DATA_W  read data or the written value
- RespState  out  2  requester's resulting line state: 00 I, 01 S, 10 M
- RespError  out  1  invalid opcode or processor id
- InvValid  out  1  one-cycle invalidation strobe
- InvMask  out  2  bit n = invalidate processor n
- InvAddress  out  ADDR_W  invalidated line
- WbValid  out  1  one-cycle writeback strobe
- WbAddress  out  ADDR_W  written-back line
- StatReads, StatWrites, StatInvs, StatWbs  out  8 each  statistics; see Optional Feature

Behaviour:
- Reset:
  - All outputs 0, except ReqReady = 1.
  - FSM enters IDLE.
  - Every directory entry = U with sharers 00; memory[] and dirty[] = MEM_INIT.
  - Stat counters = 0.
- Reset mid-operation aborts the request in flight: no response, no strobes, full reinitialisation.
- Directory entry: state U/S/M (2 bits), sharer mask (2 bits). In M, exactly one sharer bit is set, and that processor is the owner.
- FSM states: IDLE -> LOOKUP -> (INVAL | WRITEBACK)? -> RESP -> IDLE.
- IDLE:
  - ReqReady = 1.
  - On ReqValid at edge T, latch all request fields and go to LOOKUP.
  - ReqValid while not in IDLE is ignored; the requester must hold the request.
- LOOKUP: decode the entry and choose the path.
  - Invalid WriteOrRead or Processor: RESP with RespError = 1, RespState = 00, RespData = 0, no state change.
- Read by p:
  - U: data = memory; entry -> S, sharers = {p}; RespState S.
  - S: data = memory; sharers |= p; RespState S.
  - M, owner p: data = dirty; unchanged; RespState M.
  - M, owner q != p: go to WRITEBACK.
    - WRITEBACK pulses WbValid with WbAddress, copies dirty to memory, sets entry -> S with sharers = {p, q}.
    - data = dirty; RespState S.
- Write by p, data d:
  - U, S with sharers subset of {p}, or M owned by p: entry -> M, owner p, dirty = d.
  - S with other sharers: go to INVAL.
    - INVAL pulses InvValid with InvMask = sharers & ~p.
    - Then entry -> M, owner p, dirty = d.
  - M owned by q != p: INVAL with InvMask = q bit (no writeback; the line is fully overwritten); entry -> M, owner p, dirty = d.
  - In all write cases RespData = d and RespState = M.
- RESP: RespValid = 1 for exactly one cycle, with RespProcessor = p.
- Latency from accept edge T:
  - RespValid high in the cycle after edge T+2 for direct paths.
  - RespValid high after edge T+3 for INVAL or WRITEBACK paths.
  - ReqReady returns in the cycle after RESP.
- Strobes never overlap RespValid; all strobes are registered outputs.

Optional Feature:
- Macro: MSI_DIR_STATS_EN.
- Defined: the four Stat* counters increment on, respectively:
  - RESP of a valid read
  - RESP of a valid write
  - each InvValid pulse
  - each WbValid pulse
  - Counters saturate at 255 and clear on Reset.
- Undefined: Stat* ports are present but tied to 0; no counter registers are synthesised.

Test Plan:
- After reset, P0,0 reads addr 0001 -> RespValid at T+2, RespData 0, RespState S; directory entry 0001 = S, sharers 01.
- P0,0 reads 0110, then P0,0 writes 0110 <- 0111 -> write response at T+2, RespState M, no InvValid (silent upgrade).
- P0,0 and P0,1 both read 0101; then P0,1 writes 0101 <- 1000 -> InvValid with InvMask 01, InvAddress 0101; RespValid at T+3, RespState M.
- P0,0 writes 0101 <- 1001 (owner P0,1) -> InvMask 10; then P0,1 reads 0101 -> WbValid with WbAddress 0101, RespData 1001, RespState S; memory[0101] = 1001.
- Request with WriteOrRead = 10 -> RespError 1 at T+2; directory unchanged. ReqValid held during a busy cycle -> accepted only once ReqReady is high.
- Reset asserted during the INVAL cycle -> no RespValid; ReqReady = 1 next cycle; entries back to U. With MSI_DIR_STATS_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/msi_directory_responder_if.sv
// Request/response bundle between the MSI request generator (master) and the
// directory responder (slave), including the side-channel strobes and statistics.
interface msi_directory_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              ReqValid;
  logic              ReqReady;
  logic [ADDR_W-1:0] AddressTest;
  logic [1:0]        WriteOrRead;
  logic [1:0]        Processor;
  logic [DATA_W-1:0] DataTest;
  logic              RespValid;
  logic [1:0]        RespProcessor;
  logic [DATA_W-1:0] RespData;
  logic [1:0]        RespState;
  logic              RespError;
  logic              InvValid;
  logic [1:0]        InvMask;
  logic [ADDR_W-1:0] InvAddress;
  logic              WbValid;
  logic [ADDR_W-1:0] WbAddress;
  logic [7:0]        StatReads;
  logic [7:0]        StatWrites;
  logic [7:0]        StatInvs;
  logic [7:0]        StatWbs;

  modport master (
    output ReqValid, AddressTest, WriteOrRead, Processor, DataTest,
    input  ReqReady, RespValid, RespProcessor, RespData, RespState, RespError,
    input  InvValid, InvMask, InvAddress, WbValid, WbAddress,
    input  StatReads, StatWrites, StatInvs, StatWbs
  );

  modport slave (
    input  ReqValid, AddressTest, WriteOrRead, Processor, DataTest,
    output ReqReady, RespValid, RespProcessor, RespData, RespState, RespError,
    output InvValid, InvMask, InvAddress, WbValid, WbAddress,
    output StatReads, StatWrites, StatInvs, StatWbs
  );
endinterface

// File: rtl/msi_directory_responder.sv
// Two-processor MSI directory with backing memory; one response per request plus
// invalidation/writeback strobes. Define MSI_DIR_STATS_EN for saturating statistics.
module msi_directory_responder #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int MEM_INIT = 0
) (
  input logic                     i_clk,
  input logic                     i_rst,
  msi_directory_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] INIT_W = DATA_W'(MEM_INIT);

  // state     | meaning
  // IDLE      | ReqReady high, waiting for a request
  // DECODE    | latch directory entry of the request address
  // LOOKUP    | choose path, commit directory/memory update
  // INVAL     | InvValid pulse
  // WRITEBACK | WbValid pulse
  // RESP      | RespValid pulse
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_LOOKUP, S_INVAL, S_WRITEBACK, S_RESP} state_t;
  localparam logic [1:0] DIR_U = 2'b00, DIR_S = 2'b01, DIR_M = 2'b10;

  state_t            r_state;
  logic [1:0]        r_dir_st [DEPTH];
  logic [1:0]        r_dir_sh [DEPTH];
  logic [DATA_W-1:0] r_mem    [DEPTH];
  logic [DATA_W-1:0] r_dirty  [DEPTH];

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_op, r_proc;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_ent_st, r_ent_sh;
  logic [DATA_W-1:0] r_ent_mem, r_ent_dirty;
  logic [DATA_W-1:0] r_pend_data;
  logic [1:0]        r_pend_state;

  logic              r_req_ready, r_resp_valid, r_resp_error, r_inv_valid, r_wb_valid;
  logic [1:0]        r_resp_proc, r_resp_state, r_inv_mask;
  logic [DATA_W-1:0] r_resp_data;
  logic [ADDR_W-1:0] r_inv_addr, r_wb_addr;

  logic              w_err, w_inv, w_wb, w_wr_dirty, w_wr_mem;
  logic [1:0]        w_pbit, w_new_st, w_new_sh, w_rstate, w_inv_mask;
  logic [DATA_W-1:0] w_rdata;

  assign w_err      = r_op[1] | r_proc[1];
  assign w_pbit     = r_proc[0] ? 2'b10 : 2'b01;
  assign w_inv_mask = r_ent_sh & ~w_pbit;

  always_comb begin
    w_rdata    = '0;
    w_rstate   = DIR_U;
    w_new_st   = r_ent_st;
    w_new_sh   = r_ent_sh;
    w_wr_dirty = 1'b0;
    w_wr_mem   = 1'b0;
    w_inv      = 1'b0;
    w_wb       = 1'b0;
    if (!w_err) begin
      if (r_op[0]) begin
        // Any other holder (sharer or owner) is invalidated; the line is fully overwritten.
        w_new_st   = DIR_M;
        w_new_sh   = w_pbit;
        w_wr_dirty = 1'b1;
        w_rdata    = r_data;
        w_rstate   = DIR_M;
        w_inv      = |w_inv_mask;
      end else begin
        case (r_ent_st)
          DIR_M: begin
            w_rdata = r_ent_dirty;
            if (r_ent_sh == w_pbit) begin
              w_rstate = DIR_M;
            end else begin
              w_wb     = 1'b1;
              w_wr_mem = 1'b1;
              w_new_st = DIR_S;
              w_new_sh = r_ent_sh | w_pbit;
              w_rstate = DIR_S;
            end
          end
          DIR_S: begin
            w_rdata  = r_ent_mem;
            w_new_sh = r_ent_sh | w_pbit;
            w_rstate = DIR_S;
          end
          default: begin
            w_rdata  = r_ent_mem;
            w_new_st = DIR_S;
            w_new_sh = w_pbit;
            w_rstate = DIR_S;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_proc  <= '0;
      r_resp_data  <= '0;
      r_resp_state <= '0;
      r_inv_valid  <= 1'b0;
      r_inv_mask   <= '0;
      r_inv_addr   <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_addr       <= '0;
      r_op         <= '0;
      r_proc       <= '0;
      r_data       <= '0;
      r_ent_st     <= DIR_U;
      r_ent_sh     <= '0;
      r_ent_mem    <= '0;
      r_ent_dirty  <= '0;
      r_pend_data  <= '0;
      r_pend_state <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dir_st[i] <= DIR_U;
        r_dir_sh[i] <= 2'b00;
        r_mem[i]    <= INIT_W;
        r_dirty[i]  <= INIT_W;
      end
    end else begin
      r_inv_valid <= 1'b0;
      r_inv_mask  <= '0;
      r_inv_addr  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.ReqValid) begin
            r_addr      <= bus.AddressTest;
            r_op        <= bus.WriteOrRead;
            r_proc      <= bus.Processor;
            r_data      <= bus.DataTest;
            r_req_ready <= 1'b0;
            r_state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_ent_st    <= r_dir_st[r_addr];
          r_ent_sh    <= r_dir_sh[r_addr];
          r_ent_mem   <= r_mem[r_addr];
          r_ent_dirty <= r_dirty[r_addr];
          r_state     <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_pend_data  <= w_rdata;
          r_pend_state <= w_rstate;
          if (!w_err) begin
            r_dir_st[r_addr] <= w_new_st;
            r_dir_sh[r_addr] <= w_new_sh;
            if (w_wr_dirty) r_dirty[r_addr] <= r_data;
            if (w_wr_mem)   r_mem[r_addr]   <= r_ent_dirty;
          end
          if (w_inv) begin
            r_inv_valid <= 1'b1;
            r_inv_mask  <= w_inv_mask;
            r_inv_addr  <= r_addr;
            r_state     <= S_INVAL;
          end else if (w_wb) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_addr;
            r_state    <= S_WRITEBACK;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_proc  <= r_proc;
            r_resp_data  <= w_rdata;
            r_resp_state <= w_rstate;
            r_resp_error <= w_err;
            r_state      <= S_RESP;
          end
        end
        S_INVAL, S_WRITEBACK: begin
          r_resp_valid <= 1'b1;
          r_resp_proc  <= r_proc;
          r_resp_data  <= r_pend_data;
          r_resp_state <= r_pend_state;
          r_resp_error <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_proc  <= '0;
          r_resp_data  <= '0;
          r_resp_state <= '0;
          r_resp_error <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ReqReady      = r_req_ready;
  assign bus.RespValid     = r_resp_valid;
  assign bus.RespProcessor = r_resp_proc;
  assign bus.RespData      = r_resp_data;
  assign bus.RespState     = r_resp_state;
  assign bus.RespError     = r_resp_error;
  assign bus.InvValid      = r_inv_valid;
  assign bus.InvMask       = r_inv_mask;
  assign bus.InvAddress    = r_inv_addr;
  assign bus.WbValid       = r_wb_valid;
  assign bus.WbAddress     = r_wb_addr;

`ifdef MSI_DIR_STATS_EN
  logic [7:0] r_stat_rd, r_stat_wr, r_stat_inv, r_stat_wb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_rd  <= '0;
      r_stat_wr  <= '0;
      r_stat_inv <= '0;
      r_stat_wb  <= '0;
    end else begin
      if (r_resp_valid && !r_resp_error && !r_op[0] && r_stat_rd != 8'hFF) r_stat_rd <= r_stat_rd + 8'd1;
      if (r_resp_valid && !r_resp_error &&  r_op[0] && r_stat_wr != 8'hFF) r_stat_wr <= r_stat_wr + 8'd1;
      if (r_inv_valid && r_stat_inv != 8'hFF) r_stat_inv <= r_stat_inv + 8'd1;
      if (r_wb_valid  && r_stat_wb  != 8'hFF) r_stat_wb  <= r_stat_wb + 8'd1;
    end
  end

  assign bus.StatReads  = r_stat_rd;
  assign bus.StatWrites = r_stat_wr;
  assign bus.StatInvs   = r_stat_inv;
  assign bus.StatWbs    = r_stat_wb;
`else
  assign bus.StatReads  = '0;
  assign bus.StatWrites = '0;
  assign bus.StatInvs   = '0;
  assign bus.StatWbs    = '0;
`endif
endmodule

// File: tb/tb_msi_directory_responder.sv
// Directed test of msi_directory_responder: MSI transitions, latencies, strobes,
// error handling, busy-hold acceptance and reset during an invalidation.
module tb_msi_directory_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msi_directory_responder_if #(.ADDR_W(4), .DATA_W(4)) bus();

  msi_directory_responder #(.ADDR_W(4), .DATA_W(4), .MEM_INIT(0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

`ifdef MSI_DIR_STATS_EN
  localparam int EXP_RD = 11, EXP_WR = 5, EXP_INV = 4, EXP_WB = 2;
`else
  localparam int EXP_RD = 0, EXP_WR = 0, EXP_INV = 0, EXP_WB = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  int         got_lat, got_np;
  logic [3:0] got_data, got_inv_addr, got_wb_addr;
  logic [1:0] got_state, got_proc, got_mask;
  logic       got_err, got_inv, got_wb, got_ovl;

  int         a_i, b_i, b_acc, np, wait_n;
  logic [3:0] a_d, b_d;
  logic [1:0] a_s, b_s;
  logic       wbseen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [1:0] op, input logic [1:0] p,
                      input logic [3:0] d);
    int n;
    @(negedge clk);
    bus.AddressTest = a;
    bus.WriteOrRead = op;
    bus.Processor   = p;
    bus.DataTest    = d;
    bus.ReqValid    = 1'b1;
    n = 0;
    while (!bus.ReqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.ReqValid = 1'b0;
    got_lat = -1; got_np = 0; got_data = '0; got_state = '0; got_proc = '0; got_err = 1'b0;
    got_inv = 1'b0; got_mask = '0; got_inv_addr = '0; got_wb = 1'b0; got_wb_addr = '0; got_ovl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.RespValid) begin
        got_np++;
        if (got_lat < 0) begin
          got_lat   = i;
          got_data  = bus.RespData;
          got_state = bus.RespState;
          got_proc  = bus.RespProcessor;
          got_err   = bus.RespError;
        end
      end
      if (bus.InvValid) begin
        got_inv = 1'b1; got_mask = bus.InvMask; got_inv_addr = bus.InvAddress;
      end
      if (bus.WbValid) begin
        got_wb = 1'b1; got_wb_addr = bus.WbAddress;
      end
      if (bus.RespValid && (bus.InvValid || bus.WbValid)) got_ovl = 1'b1;
    end
  endtask

  task automatic rq(input string tag, input logic [3:0] a, input logic [1:0] op,
                    input logic [1:0] p, input logic [3:0] d, input int e_lat,
                    input logic [3:0] e_data, input logic [1:0] e_state, input logic e_err,
                    input logic [1:0] e_mask, input logic e_wb);
    send(a, op, p, d);
    chk({tag, ".lat"},   got_lat,   e_lat);
    chk({tag, ".data"},  got_data,  e_data);
    chk({tag, ".state"}, got_state, e_state);
    chk({tag, ".err"},   got_err,   e_err);
    chk({tag, ".proc"},  got_proc,  p);
    chk({tag, ".npuls"}, got_np,    1);
    chk({tag, ".inv"},   got_inv,   (e_mask != 2'b00));
    chk({tag, ".mask"},  got_mask,  e_mask);
    if (e_mask != 2'b00) chk({tag, ".invad"}, got_inv_addr, a);
    chk({tag, ".wb"},    got_wb,    e_wb);
    if (e_wb) chk({tag, ".wbad"}, got_wb_addr, a);
    chk({tag, ".ovl"},   got_ovl,   1'b0);
  endtask

  initial begin
    bus.ReqValid = 1'b0; bus.AddressTest = '0; bus.WriteOrRead = '0;
    bus.Processor = '0; bus.DataTest = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", bus.ReqReady, 1'b1);
    chk("rst.resp",  bus.RespValid, 1'b0);
    chk("rst.data",  bus.RespData, 4'h0);
    chk("rst.inv",   bus.InvValid, 1'b0);
    chk("rst.wb",    bus.WbValid, 1'b0);
    chk("rst.strd",  bus.StatReads, 8'd0);
    chk("rst.stinv", bus.StatInvs, 8'd0);

    //      tag     addr   op     proc   data   lat data   st     err   mask   wb
    rq("r0_0001", 4'h1, 2'b00, 2'b00, 4'h0, 2, 4'h0, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("w1_0001", 4'h1, 2'b01, 2'b01, 4'h3, 3, 4'h3, 2'b10, 1'b0, 2'b01, 1'b0);
    rq("r0_0110", 4'h6, 2'b00, 2'b00, 4'h0, 2, 4'h0, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("w0_0110", 4'h6, 2'b01, 2'b00, 4'h7, 2, 4'h7, 2'b10, 1'b0, 2'b00, 1'b0);
    rq("r0_0101", 4'h5, 2'b00, 2'b00, 4'h0, 2, 4'h0, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("r1_0101", 4'h5, 2'b00, 2'b01, 4'h0, 2, 4'h0, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("w1_0101", 4'h5, 2'b01, 2'b01, 4'h8, 3, 4'h8, 2'b10, 1'b0, 2'b01, 1'b0);
    rq("w0_0101", 4'h5, 2'b01, 2'b00, 4'h9, 3, 4'h9, 2'b10, 1'b0, 2'b10, 1'b0);
    rq("r1_wb",   4'h5, 2'b00, 2'b01, 4'h0, 3, 4'h9, 2'b01, 1'b0, 2'b00, 1'b1);
    rq("r0_mem",  4'h5, 2'b00, 2'b00, 4'h0, 2, 4'h9, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("err_op",  4'h5, 2'b10, 2'b00, 4'hA, 2, 4'h0, 2'b00, 1'b1, 2'b00, 1'b0);
    rq("err_pid", 4'h5, 2'b00, 2'b10, 4'hA, 2, 4'h0, 2'b00, 1'b1, 2'b00, 1'b0);
    rq("r0_same", 4'h5, 2'b00, 2'b00, 4'h0, 2, 4'h9, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("w1_shr",  4'h5, 2'b01, 2'b01, 4'h2, 3, 4'h2, 2'b10, 1'b0, 2'b01, 1'b0);
    rq("r1_own",  4'h5, 2'b00, 2'b01, 4'h0, 2, 4'h2, 2'b10, 1'b0, 2'b00, 1'b0);

    // ReqValid held through the busy window of a prior request
    @(negedge clk);
    bus.AddressTest = 4'h6; bus.WriteOrRead = 2'b00; bus.Processor = 2'b00; bus.DataTest = 4'h0;
    bus.ReqValid = 1'b1;
    wait_n = 0;
    while (!bus.ReqReady && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    #1 bus.Processor = 2'b01;
    a_i = -1; b_i = -1; b_acc = -1; np = 0; wbseen = 1'b0;
    a_d = '0; a_s = '0; b_d = '0; b_s = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.RespValid) begin
        np++;
        if (a_i < 0) begin
          a_i = i; a_d = bus.RespData; a_s = bus.RespState;
        end else begin
          b_i = i; b_d = bus.RespData; b_s = bus.RespState;
        end
      end
      if (bus.WbValid) wbseen = 1'b1;
      if (bus.ReqReady && b_acc < 0) begin
        b_acc = i;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
      end
    end
    chk("hold.a_lat",  a_i, 2);
    chk("hold.a_data", a_d, 4'h7);
    chk("hold.a_st",   a_s, 2'b10);
    chk("hold.ready",  b_acc, 3);
    chk("hold.b_lat",  b_i, 7);
    chk("hold.b_data", b_d, 4'h7);
    chk("hold.b_st",   b_s, 2'b01);
    chk("hold.npuls",  np, 2);
    chk("hold.wb",     wbseen, 1'b1);

    rq("r0_1010", 4'hA, 2'b00, 2'b00, 4'h0, 2, 4'h0, 2'b01, 1'b0, 2'b00, 1'b0);
    chk("stat.rd",  bus.StatReads,  EXP_RD);
    chk("stat.wr",  bus.StatWrites, EXP_WR);
    chk("stat.inv", bus.StatInvs,   EXP_INV);
    chk("stat.wb",  bus.StatWbs,    EXP_WB);

    // Reset lands while the invalidation strobe is up
    @(negedge clk);
    bus.AddressTest = 4'hA; bus.WriteOrRead = 2'b01; bus.Processor = 2'b01; bus.DataTest = 4'hF;
    bus.ReqValid = 1'b1;
    wait_n = 0;
    while (!bus.ReqReady && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    #1 bus.ReqValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rinv.inv", bus.InvValid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rinv.resp",  bus.RespValid, 1'b0);
    chk("rinv.ready", bus.ReqReady, 1'b1);
    chk("rinv.invlo", bus.InvValid, 1'b0);
    np = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.RespValid) np++;
    end
    chk("rinv.npuls", np, 0);
    chk("rinv.strd",  bus.StatReads, 8'd0);
    chk("rinv.stwr",  bus.StatWrites, 8'd0);
    chk("rinv.stinv", bus.StatInvs, 8'd0);
    chk("rinv.stwb",  bus.StatWbs, 8'd0);

    rq("post_r0",  4'h5, 2'b00, 2'b00, 4'h0, 2, 4'h0, 2'b01, 1'b0, 2'b00, 1'b0);
    rq("post_w1",  4'hA, 2'b01, 2'b01, 4'h4, 2, 4'h4, 2'b10, 1'b0, 2'b00, 1'b0);
    rq("post_rwb", 4'hA, 2'b00, 2'b00, 4'h0, 3, 4'h4, 2'b01, 1'b0, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
